// File: rtl/digit_entry.sv
// Multi-digit front-panel entry: debounced inc/dec buttons with auto-repeat,
// saturate or wrap stepping, clamped preset load and a change strobe.
module digit_entry #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_W      = 4,
  parameter int MAX_VAL      = 9,
  parameter int DEB_CYCLES   = 120,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 1,
  parameter int WRAP         = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS-1:0]         sel,
  input  logic                          btn_inc,
  input  logic                          btn_dec,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
  output logic                          changed
);

  localparam int N  = NUM_DIGITS * DIGIT_W;
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DIGIT_W-1:0] MAXV = DIGIT_W'(MAX_VAL);

  // Index 0 is the increment button, index 1 the decrement button.
  logic [1:0]         raw;
  logic [1:0]         s1;
  logic [1:0]         s;
  logic [1:0]         stable;
  logic [1:0]         stable_q;
  logic [1:0]         press;
  logic [1:0]         rep;
  logic [1:0][CW-1:0] cnt;
  logic               conflict;
  logic               sel_ok;
  logic               inc_req;
  logic               dec_req;
  logic [N-1:0]       dnext;

  assign raw = {btn_dec, btn_inc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= '0;
      s        <= '0;
      stable   <= '0;
      stable_q <= '0;
      cnt      <= '0;
    end else begin
      s1       <= raw;
      s        <= s1;
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (s[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
          stable[i] <= s[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign press    = stable & ~stable_q;
  assign conflict = &stable;

  generate
    if (REPEAT_DELAY > 0) begin : g_rep
      localparam int HW = $clog2(REPEAT_DELAY + 2);
      logic [1:0][HW-1:0] hc;
      logic [1:0]         arm;

      always_comb begin
        rep = '0;
        for (int i = 0; i < 2; i++) begin
          rep[i] = stable[i] & arm[i] & ~conflict &
                   ((hc[i] + HW'(1)) == HW'(REPEAT_DELAY));
        end
      end

      // arm is only set by a fresh press, so a button left held after
      // a two-button conflict never resumes repeating on its own.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          hc  <= '0;
          arm <= '0;
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (conflict || !stable[i]) begin
              hc[i]  <= '0;
              arm[i] <= 1'b0;
            end else if (press[i]) begin
              hc[i]  <= '0;
              arm[i] <= 1'b1;
            end else if (!arm[i]) begin
              hc[i] <= '0;
            end else if (rep[i]) begin
              hc[i] <= HW'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
              hc[i] <= hc[i] + HW'(1);
            end
          end
        end
      end
    end else begin : g_norep
      assign rep = '0;
    end
  endgenerate

  assign sel_ok  = (sel != '0) &&
                   ((sel & (sel - NUM_DIGITS'(1))) == '0);
  assign inc_req = (press[0] | rep[0]) & ~conflict & sel_ok;
  assign dec_req = (press[1] | rep[1]) & ~conflict & sel_ok;

  function automatic logic [DIGIT_W-1:0] step(
    input logic [DIGIT_W-1:0] d,
    input logic               up
  );
    if (up) begin
      if (d >= MAXV) return (WRAP != 0) ? '0 : MAXV;
      return d + DIGIT_W'(1);
    end
    if (d == '0) return (WRAP != 0) ? MAXV : '0;
    return d - DIGIT_W'(1);
  endfunction

  always_comb begin
    dnext = digits;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load) begin
        if (load_val[i*DIGIT_W +: DIGIT_W] > MAXV)
          dnext[i*DIGIT_W +: DIGIT_W] = MAXV;
        else
          dnext[i*DIGIT_W +: DIGIT_W] = load_val[i*DIGIT_W +: DIGIT_W];
      end else if (sel[i] && (inc_req || dec_req)) begin
        dnext[i*DIGIT_W +: DIGIT_W] =
          step(digits[i*DIGIT_W +: DIGIT_W], inc_req);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits  <= '0;
      changed <= 1'b0;
    end else begin
      digits  <= dnext;
      changed <= (dnext != digits);
    end
  end

endmodule

// File: tb/tb_digit_entry.sv
// Bench for digit_entry: saturating and wrapping instances share stimulus
// and are checked every cycle against a window-based behavioural model.
module tb_digit_entry;

  localparam int MX  = 9;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  sel = '0;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] dg0, dg1;
  logic        ch0, ch1;

  int nchk  = 0;
  int nfail = 0;

  digit_entry #(
    .NUM_DIGITS(4), .DIGIT_W(4), .MAX_VAL(MX), .DEB_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(0)
  ) u0 (
    .clk(clk), .rst(rst), .sel(sel), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .load(load), .load_val(load_val),
    .digits(dg0), .changed(ch0)
  );

  digit_entry #(
    .NUM_DIGITS(4), .DIGIT_W(4), .MAX_VAL(MX), .DEB_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .WRAP(1)
  ) u1 (
    .clk(clk), .rst(rst), .sel(sel), .btn_inc(btn_inc),
    .btn_dec(btn_dec), .load(load), .load_val(load_val),
    .digits(dg1), .changed(ch1)
  );

  always #5 clk = ~clk;

  // Model state: w=0 saturating, w=1 wrapping; button 0 inc, 1 dec.
  int m_d [2][4];
  bit m_ch [2];
  bit st [2];
  bit armed [2];
  int pe [2] = '{-100, -100};
  bit hist [2][8];
  int cyc = 0;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack(input int w);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'(m_d[w][k]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      st[i] = 0;
      armed[i] = 0;
      pe[i] = -100;
      m_ch[i] = 0;
      for (int k = 0; k < 8; k++) hist[i][k] = 0;
      for (int k = 0; k < 4; k++) m_d[i][k] = 0;
    end
  endtask

  // A level is accepted once the last DEB synchronised samples all
  // disagree with it; the step lands one edge later.
  task automatic model_tick();
    bit conf, ev [2], raw [2], diff;
    int old [2][4];
    int idx, d, f;
    raw[0] = btn_inc;
    raw[1] = btn_dec;
    conf = st[0] && st[1];
    for (int i = 0; i < 2; i++) begin
      ev[i] = 0;
      if (!st[i] || conf) armed[i] = 0;
      else if (cyc == pe[i]) begin
        ev[i] = 1;
        armed[i] = 1;
      end else if (armed[i] && cyc - pe[i] >= RD &&
                   (cyc - pe[i] - RD) % RR == 0)
        ev[i] = 1;
    end
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 4; k++) old[w][k] = m_d[w][k];
    if (load) begin
      for (int w = 0; w < 2; w++)
        for (int k = 0; k < 4; k++) begin
          f = int'((load_val >> (4*k)) & 16'hF);
          m_d[w][k] = (f > MX) ? MX : f;
        end
    end else if ($countones(sel) == 1 && (ev[0] || ev[1])) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (sel[k]) idx = k;
      for (int w = 0; w < 2; w++) begin
        d = m_d[w][idx];
        if (ev[0]) m_d[w][idx] = (d == MX) ? ((w == 1) ? 0 : MX) : d + 1;
        else m_d[w][idx] = (d == 0) ? ((w == 1) ? MX : 0) : d - 1;
      end
    end
    for (int w = 0; w < 2; w++) begin
      m_ch[w] = 0;
      for (int k = 0; k < 4; k++)
        if (m_d[w][k] != old[w][k]) m_ch[w] = 1;
    end
    for (int i = 0; i < 2; i++) begin
      diff = 1;
      for (int k = 1; k <= DEB; k++) if (hist[i][k] == st[i]) diff = 0;
      if (diff) begin
        st[i] = !st[i];
        if (st[i]) pe[i] = cyc + 1;
      end
      for (int k = 7; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = raw[i];
    end
    cyc++;
  endtask

  always @(negedge rst) model_reset();
  always @(posedge clk) if (rst) model_tick();

  always @(negedge clk) begin
    check("dig_sat", dg0, pack(0));
    check("chg_sat", 16'(ch0), 16'(m_ch[0]));
    check("dig_wrap", dg1, pack(1));
    check("chg_wrap", 16'(ch1), 16'(m_ch[1]));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap(input bit dec, input int hold);
    if (dec) btn_dec = 1'b1;
    else btn_inc = 1'b1;
    tick(hold);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick(12);
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    load = 1'b1;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_dig", dg0, 16'h0000);
    check("rst_chg", 16'(ch0), 16'h0000);
    tick(2);
    rst = 1'b1;
    tick(2);

    // First press: step exactly at edge 6 after the first sample.
    sel = 4'b0001;
    btn_inc = 1'b1;
    tick(6);
    check("t1_edge5", dg0, 16'h0000);
    tick(1);
    check("t1_edge6", dg0, 16'h0001);
    check("t1_chg", 16'(ch0), 16'h0001);
    tick(1);
    btn_inc = 1'b0;
    tick(15);
    check("t1_final", dg1, 16'h0001);

    // Short glitch on dec never reaches the debounced level.
    do_load(16'h0051);
    sel = 4'b0010;
    tick(2);
    btn_dec = 1'b1;
    tick(3);
    btn_dec = 1'b0;
    tick(12);
    check("t2_glitch", dg0, 16'h0051);

    // Saturate versus wrap at both ends.
    do_load(16'h0951);
    sel = 4'b0100;
    tick(2);
    tap(1'b0, 6);
    check("t3_sat_hi", dg0, 16'h0951);
    check("t3_wrap_hi", dg1, 16'h0051);
    tap(1'b1, 6);
    check("t3_dec", dg0, 16'h0851);
    check("t3_wrap_lo", dg1, 16'h0951);

    // Auto-repeat: press plus seven repeats.
    sel = 4'b1000;
    btn_inc = 1'b1;
    tick(30);
    btn_inc = 1'b0;
    tick(14);
    check("t4_rep_sat", dg0, 16'h8851);
    check("t4_rep_wrap", dg1, 16'h8951);
    sel = 4'b1100;
    tap(1'b0, 6);
    check("t4_multihot", dg0, 16'h8851);

    // Second button cancels repeat; it does not resume afterwards.
    sel = 4'b0001;
    btn_inc = 1'b1;
    tick(20);
    btn_dec = 1'b1;
    tick(15);
    btn_dec = 1'b0;
    tick(20);
    btn_inc = 1'b0;
    tick(14);
    check("t5_conf_sat", dg0, 16'h8856);
    check("t5_conf_wrap", dg1, 16'h8956);

    // Load wins over a coincident press and clamps each field.
    btn_inc = 1'b1;
    tick(6);
    load_val = 16'hF3A7;
    load = 1'b1;
    tick(1);
    load = 1'b0;
    check("t6_load", dg0, 16'h9397);
    check("t6_load_w", dg1, 16'h9397);
    check("t6_chg", 16'(ch0), 16'h0001);
    tick(6);

    // Async reset mid-hold, then a fresh debounced press.
    #2 rst = 1'b0;
    #1 check("t7_async", dg0, 16'h0000);
    check("t7_async_w", dg1, 16'h0000);
    tick(3);
    rst = 1'b1;
    tick(8);
    btn_inc = 1'b0;
    tick(12);
    check("t7_repress", dg0, 16'h0001);
    check("t7_repress_w", dg1, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
